// File: rtl/tt_response_checker.sv
// ---------------------------------------------------------------------------
// tt_response_checker
//   Receiving end of an exhaustive-vector test flow. Holds a golden truth
//   table (2**N_IN entries of N_OUT bits), compares each accepted
//   (pattern, response) pair against it, and reports the mismatch count,
//   the first failing pattern and an overall pass flag once every pattern
//   has been seen at least once.
//
// Ports
//   CK                clock, all state changes on posedge
//   reset             asynchronous active-low reset
//   gld_we/addr/data  golden-table write; honoured only when not running
//   start             one-cycle pulse; starts or restarts a run
//   vec_valid/ready   pair handshake; vec_ready is the registered busy state
//   vec_pat/vec_resp  applied pattern / observed response
//   busy, done, pass  run status
//   mismatch_cnt      saturating count of failing transfers
//   first_fail_valid  a mismatch has been seen this run
//   first_fail_pat    pattern of the first mismatch of this run
// ---------------------------------------------------------------------------
module tt_response_checker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             gld_we,
  input  logic [N_IN-1:0]  gld_addr,
  input  logic [N_OUT-1:0] gld_data,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [N_IN-1:0]  vec_pat,
  input  logic [N_OUT-1:0] vec_resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    mismatch_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_pat
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN:0] CNT_ONE = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_OUT-1:0]  gold_q [DEPTH];
  logic [N_OUT-1:0]  gold_d [DEPTH];
  logic [DEPTH-1:0]  seen_q, seen_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffp_q, ffp_d;
  logic              xfer;
  logic              mismatch;

  always_comb begin
    state_d  = state_q;
    gold_d   = gold_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffp_d    = ffp_q;
    // A pair offered in the same cycle as start is dropped: the restart wins.
    xfer     = (state_q == S_RUN) && vec_valid && !start;
    mismatch = (vec_resp != gold_q[vec_pat]);

    if (gld_we && (state_q != S_RUN))
      gold_d[gld_addr] = gld_data;

    if (start) begin
      state_d = S_RUN;
      seen_d  = '0;
      cnt_d   = '0;
      ffv_d   = 1'b0;
      ffp_d   = '0;
    end else if (xfer) begin
      seen_d[vec_pat] = 1'b1;
      if (mismatch) begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_ONE;
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffp_d = vec_pat;
        end
      end
      // Completion is judged on the updated bitmap so the final transfer counts.
      if (&seen_d)
        state_d = S_DONE;
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gold_q  <= '{default: '0};
      seen_q  <= '0;
      cnt_q   <= '0;
      ffv_q   <= 1'b0;
      ffp_q   <= '0;
    end else begin
      state_q <= state_d;
      gold_q  <= gold_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffp_q   <= ffp_d;
    end
  end

  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign vec_ready        = busy;
  assign pass             = done && (cnt_q == '0);
  assign mismatch_cnt     = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_pat   = ffp_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// ---------------------------------------------------------------------------
// tb_tt_response_checker
//   Directed scenarios plus a randomized phase, checked every cycle against
//   a behavioural model of the checker kept in plain integer variables.
// ---------------------------------------------------------------------------
module tb_tt_response_checker;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1;
  localparam int NPAT  = 8;
  localparam int SAT   = 15;

  logic             CK = 1'b0;
  logic             reset = 1'b0;
  logic             gld_we = 1'b0;
  logic [N_IN-1:0]  gld_addr = '0;
  logic [N_OUT-1:0] gld_data = '0;
  logic             start = 1'b0;
  logic             vec_valid = 1'b0;
  logic             vec_ready;
  logic [N_IN-1:0]  vec_pat = '0;
  logic [N_OUT-1:0] vec_resp = '0;
  logic             busy, done, pass;
  logic [N_IN:0]    mismatch_cnt;
  logic             first_fail_valid;
  logic [N_IN-1:0]  first_fail_pat;

  tt_response_checker #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .CK(CK), .reset(reset), .gld_we(gld_we), .gld_addr(gld_addr),
    .gld_data(gld_data), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_pat(vec_pat), .vec_resp(vec_resp),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_pat(first_fail_pat)
  );

  always #5 CK = ~CK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  int m_mode;
  int m_gold [NPAT];
  bit m_seen [NPAT];
  int m_cnt;
  bit m_ffv;
  int m_ffp;

  function automatic void m_reset();
    m_mode = 0; m_cnt = 0; m_ffv = 0; m_ffp = 0;
    for (int i = 0; i < NPAT; i++) begin m_gold[i] = 0; m_seen[i] = 0; end
  endfunction

  function automatic void m_edge();
    int covered;
    if (gld_we && m_mode != 1) m_gold[gld_addr] = int'(gld_data);
    if (start) begin
      m_mode = 1; m_cnt = 0; m_ffv = 0; m_ffp = 0;
      for (int i = 0; i < NPAT; i++) m_seen[i] = 0;
    end else if (m_mode == 1 && vec_valid) begin
      if (int'(vec_resp) != m_gold[vec_pat]) begin
        if (m_cnt < SAT) m_cnt++;
        if (!m_ffv) begin m_ffv = 1; m_ffp = int'(vec_pat); end
      end
      m_seen[vec_pat] = 1;
      covered = 0;
      for (int i = 0; i < NPAT; i++) covered += int'(m_seen[i]);
      if (covered == NPAT) m_mode = 2;
    end
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".busy"},  32'(busy),             32'(m_mode == 1));
    check({tag, ".ready"}, 32'(vec_ready),        32'(m_mode == 1));
    check({tag, ".done"},  32'(done),             32'(m_mode == 2));
    check({tag, ".pass"},  32'(pass),             32'(m_mode == 2 && m_cnt == 0));
    check({tag, ".cnt"},   32'(mismatch_cnt),     32'(m_cnt));
    check({tag, ".ffv"},   32'(first_fail_valid), 32'(m_ffv));
    check({tag, ".ffp"},   32'(first_fail_pat),   32'(m_ffp));
  endtask

  task automatic cycle(input string tag);
    m_edge();
    @(posedge CK);
    #1;
    check_outs(tag);
  endtask

  task automatic write_gold(input int a, input int d);
    gld_we = 1'b1; gld_addr = N_IN'(a); gld_data = N_OUT'(d);
    cycle("wr");
    gld_we = 1'b0;
  endtask

  task automatic load_parity();
    logic [N_IN-1:0] p;
    for (int i = 0; i < NPAT; i++) begin
      p = N_IN'(i);
      write_gold(i, int'(^p));
    end
  endtask

  task automatic do_start();
    start = 1'b1; cycle("start"); start = 1'b0;
  endtask

  task automatic send(input int p, input int r, input string tag);
    vec_valid = 1'b1; vec_pat = N_IN'(p); vec_resp = N_OUT'(r);
    cycle(tag);
    vec_valid = 1'b0;
  endtask

  function automatic int par(input int p);
    logic [N_IN-1:0] v;
    v = N_IN'(p);
    return int'(^v);
  endfunction

  task automatic do_reset();
    @(negedge CK);
    reset = 1'b0;
    #1;
    m_reset();
    check_outs("rst");
    @(negedge CK);
    reset = 1'b1;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge CK);
    #1;
    check_outs("init");
    @(negedge CK);
    reset = 1'b1;

    // 1: all matching
    load_parity();
    do_start();
    for (int p = 0; p < NPAT; p++) send(p, par(p), "t1");
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_cnt",  32'(mismatch_cnt), 32'd0);

    // 2: pattern 5 wrong
    do_start();
    for (int p = 0; p < NPAT; p++) send(p, (p == 5) ? 1 : par(p), "t2");
    check("t2_cnt", 32'(mismatch_cnt), 32'd1);
    check("t2_ffp", 32'(first_fail_pat), 32'd5);
    check("t2_pass", 32'(pass), 32'd0);

    // 3: duplicates don't advance coverage
    do_start();
    send(7, 0, "t3"); send(0, 0, "t3"); send(7, 0, "t3");
    for (int p = 1; p <= 5; p++) send(p, par(p), "t3");
    check("t3_not_done", 32'(done), 32'd0);
    send(6, par(6), "t3");
    check("t3_done", 32'(done), 32'd1);
    check("t3_cnt",  32'(mismatch_cnt), 32'd2);
    check("t3_ffp",  32'(first_fail_pat), 32'd7);

    // 4: saturation
    do_start();
    for (int k = 0; k < 20; k++) send(0, 1, "t4");
    check("t4_cnt", 32'(mismatch_cnt), 32'd15);
    check("t4_ready", 32'(vec_ready), 32'd1);

    // 5: reset mid-run, then a fresh run
    do_start();
    for (int p = 0; p < 4; p++) send(p, 1 - par(p), "t5a");
    do_reset();
    check("t5_cnt_cleared", 32'(mismatch_cnt), 32'd0);
    load_parity();
    do_start();
    for (int p = NPAT - 1; p >= 0; p--) send(p, par(p), "t5b");
    check("t5_pass", 32'(pass), 32'd1);

    // 6: golden writes ignored in RUN, honoured in DONE
    do_start();
    write_gold(2, 1);
    for (int p = 0; p < NPAT; p++) send(p, par(p), "t6a");
    check("t6_cnt_run", 32'(mismatch_cnt), 32'd0);
    write_gold(2, 1);
    check("t6_pass_kept", 32'(pass), 32'd1);
    do_start();
    for (int p = 0; p < NPAT; p++) send(p, (p == 2) ? 0 : par(p), "t6b");
    check("t6_cnt_done", 32'(mismatch_cnt), 32'd1);
    check("t6_ffp", 32'(first_fail_pat), 32'd2);

    // start with a valid pair in the same cycle: the pair is dropped
    vec_valid = 1'b1; vec_pat = 3'd1; vec_resp = 1'b1; start = 1'b1;
    cycle("drop");
    start = 1'b0; vec_valid = 1'b0;
    check("drop_cnt", 32'(mismatch_cnt), 32'd0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      start     = ($urandom_range(0, 29) == 0);
      gld_we    = ($urandom_range(0, 7) == 0);
      gld_addr  = N_IN'($urandom);
      gld_data  = N_OUT'($urandom);
      vec_valid = ($urandom_range(0, 1) == 1);
      vec_pat   = N_IN'($urandom);
      vec_resp  = ($urandom_range(0, 3) == 0) ? N_OUT'(~m_gold[vec_pat]) : N_OUT'(m_gold[vec_pat]);
      cycle("rnd");
      if (k == 300) do_reset();
    end
    start = 1'b0; gld_we = 1'b0; vec_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
